// File: rtl/score_event_arbiter.sv
// Score control for a two-player counter: switch edge detection, round-robin command
// arbitration, and the play/hold-off/wait-for-restart game sequencing.
module score_event_arbiter #(
    parameter int WIN_SCORE      = 9,
    parameter int HOLDOFF_CYCLES = 25000000,
    parameter int FLASH_CYCLES   = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Switch,
    output logic [3:0] o_Score_1,
    output logic [3:0] o_Score_2,
    output logic [3:0] o_Grant,
    output logic       o_Game_Over,
    output logic [1:0] o_Winner,
    output logic       o_Blank
);

    localparam int HOLD_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);
    localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);
    localparam logic [3:0]         WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [3:0]         WIN_M1     = 4'(WIN_SCORE - 1);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          score1_q, score1_d;
    logic [3:0]          score2_q, score2_d;
    logic [3:0]          pending_q, pending_d;
    logic [3:0]          prev_q;
    logic [3:0]          grant_q, grant_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          winner_q, winner_d;
    logic                blank_q, blank_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FLASH_W-1:0]  flash_q, flash_d;

    logic [3:0]          rise;
    logic                grant_vld;
    logic [1:0]          grant_idx;
    logic [1:0]          scan_idx;
    logic [3:0]          grant_vec;
    logic                win;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rise
            assign rise[gi] = i_Switch[gi] & ~prev_q[gi];
        end
    endgenerate

    // Scan downward in rotation distance so the closest set bit to the pointer wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (pending_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant_vec = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
    end

    always_comb begin
        state_d   = state_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        blank_d   = blank_q;
        hold_d    = hold_q;
        flash_d   = flash_q;
        grant_d   = 4'b0000;
        win       = 1'b0;

        if (state_q != PLAY) begin
            if (flash_q == FLASH_LAST) begin
                flash_d = '0;
                blank_d = ~blank_q;
            end else begin
                flash_d = flash_q + FLASH_ONE;
            end
        end

        case (state_q)
            PLAY: begin
                pending_d = (pending_q & ~grant_vec) | rise;
                flash_d   = '0;
                blank_d   = 1'b0;
                if (grant_vld) begin
                    grant_d = grant_vec;
                    ptr_d   = grant_idx + 2'd1;
                    case (grant_idx)
                        2'd0: begin
                            if (score1_q >= WIN_M1) begin
                                score1_d = WIN_VAL;
                                winner_d = 2'b01;
                                win      = 1'b1;
                            end else begin
                                score1_d = score1_q + 4'd1;
                            end
                        end
                        2'd1: score1_d = 4'd0;
                        2'd2: begin
                            if (score2_q >= WIN_M1) begin
                                score2_d = WIN_VAL;
                                winner_d = 2'b10;
                                win      = 1'b1;
                            end else begin
                                score2_d = score2_q + 4'd1;
                            end
                        end
                        default: score2_d = 4'd0;
                    endcase
                end
                if (win) begin
                    state_d   = HOLD;
                    pending_d = 4'b0000;
                    hold_d    = '0;
                    blank_d   = 1'b1;
                end
            end
            HOLD: begin
                pending_d = 4'b0000;
                if (hold_q == HOLD_LAST) begin
                    state_d = WAIT;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                pending_d = 4'b0000;
                // The restarting press is swallowed here, never turned into a command.
                if (|rise) begin
                    state_d  = PLAY;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = 2'b00;
                    blank_d  = 1'b0;
                    flash_d  = '0;
                    ptr_d    = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= PLAY;
            score1_q  <= 4'd0;
            score2_q  <= 4'd0;
            pending_q <= 4'b0000;
            prev_q    <= 4'b0000;
            grant_q   <= 4'b0000;
            ptr_q     <= 2'd0;
            winner_q  <= 2'b00;
            blank_q   <= 1'b0;
            hold_q    <= '0;
            flash_q   <= '0;
        end else begin
            state_q   <= state_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            pending_q <= pending_d;
            prev_q    <= i_Switch;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            winner_q  <= winner_d;
            blank_q   <= blank_d;
            hold_q    <= hold_d;
            flash_q   <= flash_d;
        end
    end

    assign o_Score_1   = score1_q;
    assign o_Score_2   = score2_q;
    assign o_Grant     = grant_q;
    assign o_Game_Over = (state_q != PLAY);
    assign o_Winner    = winner_q;
    assign o_Blank     = blank_q;

endmodule
